// File: rtl/pipeline_pkg.sv
// Shared definitions for the instruction-fetch slice of the 5-stage MIPS pipeline.
//   RESET_PC_DEF / EXC_PC_DEF : default reset PC and exception vector
//   NOP_INSTR                 : instruction word used to clear the fetch queue
//   fetch_state_e             : fetch sequencer states
//   fetch_entry_t             : one fetch-queue entry {instr, pc_plus4}
package pipeline_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_PC_DEF   = 32'h8000_0004;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO holding fetched {instr, pc_plus4} words.
//   clk_i, reset_i : clock, synchronous active-high reset (clears entries)
//   push_i, data_i : enqueue data_i
//   pop_i          : dequeue head
//   flush_i        : discard all entries; wins over push_i/pop_i
//   full_o/empty_o : occupancy flags
//   head_o         : entry 0, registered
module fetch_queue
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);

  fetch_entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = data_i;
          else               e1_d = data_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd2) e0_d = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          // Single entry being consumed: the new word becomes the head directly.
          if (cnt_q == 2'd1) begin
            e0_d = data_i;
          end else begin
            e0_d = e1_q;
            e1_d = data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      e0_q  <= '{instr: NOP_INSTR, pc_plus4: '0};
      e1_q  <= '{instr: NOP_INSTR, pc_plus4: '0};
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign full_o  = (cnt_q == 2'(DEPTH));
  assign empty_o = (cnt_q == 2'd0);
  assign head_o  = e0_q;

endmodule

// File: rtl/ifetch_controller.sv
// Instruction fetch sequencer: owns the PC, drives the combinational ROM,
// buffers fetched words in a 2-entry queue and hands them to IF/ID over a
// valid/ready handshake. Redirect priority: exc_req > ex_branch > id_jump.
//   clk, reset                    : clock, synchronous active-high reset
//   imem_addr / imem_instr        : ROM address (PC flop) and same-cycle data
//   if_instr/if_pc_plus4/if_valid : queue head towards decode
//   id_ready                      : decode accepts head this cycle
//   id_jump/id_target             : ID jump redirect
//   ex_branch/ex_target           : EX taken-branch redirect
//   exc_req                       : exception redirect to EXC_PC
//   halt_req / halted             : stop-fetch request (level) / HALTED status
module ifetch_controller
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_PC   = EXC_PC_DEF,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  input  logic        id_ready,
  input  logic        id_jump,
  input  logic [31:0] id_target,
  input  logic        ex_branch,
  input  logic [31:0] ex_target,
  input  logic        exc_req,
  input  logic        halt_req,
  output logic        halted
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redir_tgt;
  logic         redir, deq, push, q_full, q_empty;
  fetch_entry_t q_head;

  assign deq   = if_valid & id_ready;
  assign redir = exc_req | ex_branch | id_jump;

  always_comb begin
    redir_tgt = id_target;
    if (exc_req)        redir_tgt = EXC_PC;
    else if (ex_branch) redir_tgt = ex_target;
  end

  assign push = (state_q == FETCH) & ~redir & (~q_full | deq);

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (redir)     pc_d = redir_tgt & 32'hFFFF_FFFC;
    else if (push) pc_d = pc_q + 32'd4;

    unique case (state_q)
      FETCH, HOLD: begin
        if (redir)                 state_d = FETCH;
        else if (halt_req)         state_d = HALTED;
        else if (q_full && !deq)   state_d = HOLD;
        else                       state_d = FETCH;
      end
      HALTED: begin
        if (redir || !halt_req) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= FETCH;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  // Flush drops any dequeue in the redirect cycle, so pop is masked too.
  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .pop_i   (deq & ~redir),
    .flush_i (redir),
    .data_i  ('{instr: imem_instr, pc_plus4: pc_q + 32'd4}),
    .full_o  (q_full),
    .empty_o (q_empty),
    .head_o  (q_head)
  );

  assign imem_addr   = pc_q;
  assign if_valid    = ~q_empty;
  assign if_instr    = q_head.instr;
  assign if_pc_plus4 = q_head.pc_plus4;
  assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_ifetch_controller.sv
module tb_ifetch_controller;

  localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] T_EXC_PC   = 32'h8000_0004;

  logic        clk = 1'b0;
  logic        reset, id_ready, id_jump, ex_branch, exc_req, halt_req;
  logic [31:0] id_target, ex_target;
  logic [31:0] imem_addr, imem_instr, if_instr, if_pc_plus4;
  logic        if_valid, halted;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: rom_word = 32'h2004_0003;
      32'h0000_0004: rom_word = 32'h0c00_0003;
      32'h0000_0008: rom_word = 32'h1000_ffff;
      32'h0000_000C: rom_word = 32'h23bd_fff8;
      32'h0000_002C: rom_word = 32'h0000_1026;
      default:       rom_word = a ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  assign imem_instr = rom_word(imem_addr);

  ifetch_controller #(.RESET_PC(T_RESET_PC), .EXC_PC(T_EXC_PC), .QDEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .if_instr   (if_instr),
    .if_pc_plus4(if_pc_plus4),
    .if_valid   (if_valid),
    .id_ready   (id_ready),
    .id_jump    (id_jump),
    .id_target  (id_target),
    .ex_branch  (ex_branch),
    .ex_target  (ex_target),
    .exc_req    (exc_req),
    .halt_req   (halt_req),
    .halted     (halted)
  );

  // Reference model: PC value, queue of {instr, pc+4} words, fetch mode.
  localparam int M_RUN = 0, M_FULL = 1, M_HALT = 2;
  logic [31:0] m_pc;
  logic [63:0] mq[$];
  int          m_mode;
  bit          m_zero_head;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit          deq, push, full_before;
    logic [31:0] tgt;
    if (reset) begin
      m_pc = T_RESET_PC;
      mq.delete();
      m_mode = M_RUN;
      m_zero_head = 1'b1;
    end else begin
      deq = (mq.size() > 0) && id_ready;
      if (exc_req || ex_branch || id_jump) begin
        tgt  = exc_req ? T_EXC_PC : (ex_branch ? ex_target : id_target);
        m_pc = {tgt[31:2], 2'b00};
        mq.delete();
        m_mode = M_RUN;
      end else begin
        full_before = (mq.size() == 2);
        push = (m_mode == M_RUN) && (!full_before || deq);
        if (deq) void'(mq.pop_front());
        if (push) begin
          mq.push_back({rom_word(m_pc), m_pc + 32'd4});
          m_pc = m_pc + 32'd4;
          m_zero_head = 1'b0;
        end
        if (m_mode == M_HALT)  m_mode = halt_req ? M_HALT : M_RUN;
        else if (halt_req)     m_mode = M_HALT;
        else                   m_mode = (full_before && !deq) ? M_FULL : M_RUN;
      end
    end
  endtask

  task automatic compare_all();
    logic [63:0] h;
    check("imem_addr", imem_addr, m_pc);
    check("if_valid", {31'b0, if_valid}, {31'b0, mq.size() != 0});
    check("halted", {31'b0, halted}, {31'b0, m_mode == M_HALT});
    if (mq.size() != 0) begin
      h = mq[0];
      check("if_instr", if_instr, h[63:32]);
      check("if_pc_plus4", if_pc_plus4, h[31:0]);
    end else if (m_zero_head) begin
      check("rst_instr", if_instr, 32'h0);
      check("rst_pc_plus4", if_pc_plus4, 32'h0);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_redirects();
    id_jump = 1'b0; ex_branch = 1'b0; exc_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; id_ready = 1'b0; halt_req = 1'b0;
    id_target = '0; ex_target = '0;
    clear_redirects();
    step();
    step();
    check("reset_valid", {31'b0, if_valid}, 32'd0);
    check("reset_addr", imem_addr, 32'h0);

    // Streaming with decode always ready
    reset = 1'b0; id_ready = 1'b1;
    step(); check("seq0", if_instr, 32'h2004_0003); check("seq0_p4", if_pc_plus4, 32'h4);
    step(); check("seq1", if_instr, 32'h0c00_0003); check("seq1_p4", if_pc_plus4, 32'h8);
    step(); check("seq2", if_instr, 32'h1000_ffff); check("seq2_p4", if_pc_plus4, 32'hC);
    step(); check("seq3", if_instr, 32'h23bd_fff8); check("seq3_p4", if_pc_plus4, 32'h10);

    // Backpressure: queue fills, PC holds
    reset = 1'b1; step(); reset = 1'b0;
    step();
    id_ready = 1'b0;
    repeat (5) step();
    check("stall_addr", imem_addr, 32'h8);
    check("stall_instr", if_instr, 32'h2004_0003);
    id_ready = 1'b1;
    step(); check("resume0", if_instr, 32'h0c00_0003);
    step(); check("resume1", if_instr, 32'h1000_ffff);

    // EX branch beats ID jump
    id_jump = 1'b1; id_target = 32'h0C; ex_branch = 1'b1; ex_target = 32'h2C;
    step(); check("br_addr", imem_addr, 32'h2C); check("br_flush", {31'b0, if_valid}, 32'd0);
    clear_redirects();
    step(); check("br_instr", if_instr, 32'h0000_1026); check("br_p4", if_pc_plus4, 32'h30);

    // Exception beats branch; target low bits dropped
    exc_req = 1'b1; ex_branch = 1'b1; ex_target = 32'h10;
    step(); check("exc_addr", imem_addr, 32'h8000_0004);
    clear_redirects(); ex_branch = 1'b1; ex_target = 32'h0000_000E;
    step(); check("align_addr", imem_addr, 32'h0000_000C);
    clear_redirects();
    step(); step();

    // Halt with a full queue: drain, then freeze, then resume
    id_ready = 1'b0;
    repeat (3) step();
    halt_req = 1'b1; id_ready = 1'b1;
    step(); step();
    check("halt_valid", {31'b0, if_valid}, 32'd0);
    check("halt_flag", {31'b0, halted}, 32'd1);
    step(); step();
    halt_req = 1'b0;
    repeat (3) step();

    // PC wrap at top of address space
    ex_branch = 1'b1; ex_target = 32'hFFFF_FFFC;
    step(); clear_redirects();
    step(); check("wrap_p4", if_pc_plus4, 32'h0); check("wrap_addr", imem_addr, 32'h0);

    // Reset wins over a simultaneous branch
    reset = 1'b1; ex_branch = 1'b1; ex_target = 32'h40;
    step(); check("rst_br_addr", imem_addr, 32'h0); check("rst_br_valid", {31'b0, if_valid}, 32'd0);
    reset = 1'b0; clear_redirects();
    step(); check("rst_restart", if_instr, 32'h2004_0003);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      id_ready  = ($urandom_range(0, 3) != 0);
      exc_req   = ($urandom_range(0, 39) == 0);
      ex_branch = ($urandom_range(0, 19) == 0);
      id_jump   = ($urandom_range(0, 19) == 0);
      ex_target = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
      id_target = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
      if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
